arbitro_memoria: RTL and testbench
==================================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 The block SHALL have parameter MAX_CICLOS, default 16, giving the maximum cycles one requester may hold the grant.
REQ-002 The block SHALL have parameter CONT_WIDTH, default 5, giving the hold-counter width; it must satisfy 2^CONT_WIDTH > MAX_CICLOS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_0, input, 1 bit: access request from requester 0 (pipeline data access).
REQ-006 The block SHALL have port req_1, input, 1 bit: access request from requester 1 (debug unit).
REQ-007 The block SHALL have port fin_0, input, 1 bit: end-of-transaction pulse from requester 0.
REQ-008 The block SHALL have port fin_1, input, 1 bit: end-of-transaction pulse from requester 1.
REQ-009 The block SHALL have port grant_0, output, 1 bit: requester 0 owns the shared 32-bit path.
REQ-010 The block SHALL have port grant_1, output, 1 bit: requester 1 owns the shared 32-bit path.
REQ-011 The block SHALL have port selectorMUX, output, 1 bit: drives the select of the shared 2:1 32-bit mux (0 = requester 0, 1 = requester 1).
REQ-012 The block SHALL have port ocupado, output, 1 bit: high whenever any grant is active.
REQ-013 The block SHALL have port timeout_error, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT_0 and GRANT_1.
REQ-015 All outputs SHALL be registered and decoded from the state: grant_0 = (GRANT_0), grant_1 = (GRANT_1), selectorMUX = (GRANT_1), ocupado = grant_0 | grant_1.
REQ-016 grant_0 and grant_1 SHALL never be high together, including at reset and at handover.
REQ-017 In IDLE with exactly one req_x high, the next state SHALL be GRANT_x, so the grant appears one cycle after the request is sampled.
REQ-018 In IDLE with both requests high, the grant SHALL go to the requester that is not recorded in register ultimo.
REQ-019 Register ultimo SHALL be updated to x on every entry into GRANT_x.
REQ-020 In GRANT_x, a release SHALL occur on fin_x = 1, on req_x = 0, or on a forced release (REQ-023).
REQ-021 On release from GRANT_x, the next state SHALL be GRANT_y if req_y = 1 (direct handover, no idle cycle), otherwise IDLE.
REQ-022 Counter cont SHALL clear on every state entry and increment each cycle spent in GRANT_x.
REQ-023 A forced release SHALL occur when cont = MAX_CICLOS-1 with no release; timeout_error SHALL be high for exactly the following cycle.
REQ-024 A forced release SHALL use the same next-state rule as REQ-021.
REQ-025 fin_y or req_y activity from the non-granted requester SHALL be ignored, apart from the handover decision.
REQ-026 A fin_x pulse arriving in the same cycle as the forced-release condition SHALL count as a normal release, with no timeout_error.
REQ-027 cont SHALL saturate and never wrap; it is unused in IDLE.

Reset
REQ-028 While reset = 1 at a clock edge, the state SHALL become IDLE, ultimo = 1, cont = 0, and all outputs 0.
REQ-029 A reset asserted mid-grant SHALL drop the grant on the next edge; no timeout_error shall be generated.
REQ-030 The first request after reset SHALL be evaluated in the cycle after reset deasserts.

Structure
REQ-031 State encodings (IDLE=2'b00, GRANT_0=2'b01, GRANT_1=2'b10) SHALL live in the shared definitions package/include, together with the default MAX_CICLOS.
REQ-032 The block SHALL have one natural sub-module, contador_timeout, holding the clear/increment/saturate counter and providing the terminal-count flag; the FSM and ultimo stay in arbitro_memoria.

Verification
REQ-033 Reset, then req_0=1 at cycle 0, fin_0 at cycle 3 -> grant_0=1 at cycles 1-3, selectorMUX=0, IDLE at cycle 4.
REQ-034 Reset, then req_0=req_1=1 together -> grant_0 first (ultimo=1); on fin_0 with req_1 still high -> grant_1 on the next cycle, no idle cycle, and grants never overlap.
REQ-035 Both requests held continuously, each granted side pulses fin every 2 cycles -> grants alternate 0,1,0,1.
REQ-036 MAX_CICLOS=16, req_1 held with no fin -> grant_1 for exactly 16 cycles, then timeout_error=1 for 1 cycle, IDLE, then grant_1 re-granted.
REQ-037 fin_1 coincides with cont=15 -> normal release, timeout_error stays 0.
REQ-038 reset asserted during GRANT_1 at cont=7 -> all outputs 0 next cycle; req_0 pending -> grant_0 granted two cycles after reset deasserts at the earliest.

Source files
------------

// File: rtl/arbitro_memoria_pkg.sv
// arbitro_memoria_pkg: shared state encodings and defaults for the memory arbiter
package arbitro_memoria_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_0 = 2'b01,
        GRANT_1 = 2'b10
    } estado_t;
    localparam int MAX_CICLOS_DEF = 16;
    localparam int CONT_WIDTH_DEF = 5;
endpackage

// File: rtl/arbitro_memoria_contador_timeout.sv
// contador_timeout: clear/increment/saturate hold counter with terminal-count flag
module contador_timeout #(
    parameter int MAX_CICLOS = 16,
    parameter int CONT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [CONT_WIDTH-1:0] o_cont,
    output logic                  o_tc
);
    logic [CONT_WIDTH-1:0] r_cont;
    // Clear on reset or state entry, otherwise count grant cycles without wrapping
    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cont <= '0;
        else if (i_inc && r_cont != '1)
            r_cont <= r_cont + 1'b1;
    end
    assign o_cont = r_cont;
    assign o_tc   = (r_cont == CONT_WIDTH'(MAX_CICLOS - 1));
endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-requester arbiter for the shared 32-bit memory path with hold timeout
module arbitro_memoria
    import arbitro_memoria_pkg::*;
#(
    parameter int MAX_CICLOS = MAX_CICLOS_DEF,
    parameter int CONT_WIDTH = CONT_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    input  logic fin_0,
    input  logic fin_1,
    output logic grant_0,
    output logic grant_1,
    output logic selectorMUX,
    output logic ocupado,
    output logic timeout_error
);
    estado_t               r_state;
    estado_t               w_next;
    logic                  r_ultimo;
    logic                  r_timeout;
    logic                  w_timeout;
    logic                  w_normal;
    logic                  w_tc;
    logic [CONT_WIDTH-1:0] w_cont;

    contador_timeout #(
        .MAX_CICLOS(MAX_CICLOS),
        .CONT_WIDTH(CONT_WIDTH)
    ) u_cont (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_next != r_state),
        .i_inc (r_state != IDLE),
        .o_cont(w_cont),
        .o_tc  (w_tc)
    );

    // Next-state decision: round-robin from IDLE, release on fin/drop/timeout with direct handover
    always_comb begin
        w_next    = r_state;
        w_normal  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:
                w_next = (req_0 && req_1) ? (r_ultimo ? GRANT_0 : GRANT_1) :
                         req_0 ? GRANT_0 : req_1 ? GRANT_1 : IDLE;
            GRANT_0: begin
                w_normal  = fin_0 || !req_0;
                w_timeout = w_tc && !w_normal;
                if (w_normal || w_tc)
                    w_next = req_1 ? GRANT_1 : IDLE;
            end
            GRANT_1: begin
                w_normal  = fin_1 || !req_1;
                w_timeout = w_tc && !w_normal;
                if (w_normal || w_tc)
                    w_next = req_0 ? GRANT_0 : IDLE;
            end
            default:
                w_next = IDLE;
        endcase
    end

    // State, last-granted record and timeout pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ultimo  <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_timeout;
            if (w_next == GRANT_0)
                r_ultimo <= 1'b0;
            else if (w_next == GRANT_1)
                r_ultimo <= 1'b1;
        end
    end

    assign grant_0       = (r_state == GRANT_0);
    assign grant_1       = (r_state == GRANT_1);
    assign selectorMUX   = (r_state == GRANT_1);
    assign ocupado       = (r_state != IDLE);
    assign timeout_error = r_timeout;
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed and random stimulus checked against a behavioural arbiter model
module tb_arbitro_memoria;
    localparam int MAX = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_0 = 1'b0, req_1 = 1'b0, fin_0 = 1'b0, fin_1 = 1'b0;
    logic grant_0, grant_1, selectorMUX, ocupado, timeout_error;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_owner = -1;
    int m_last = 1;
    int m_held = 0;
    logic m_to = 1'b0;

    arbitro_memoria #(.MAX_CICLOS(MAX), .CONT_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_0        (req_0),
        .req_1        (req_1),
        .fin_0        (fin_0),
        .fin_1        (fin_1),
        .grant_0      (grant_0),
        .grant_1      (grant_1),
        .selectorMUX  (selectorMUX),
        .ocupado      (ocupado),
        .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input logic rs, input logic r0, input logic r1, input logic f0, input logic f1);
        logic own_req, own_fin, oth_req, normal, forced;
        if (rs) begin
            m_owner = -1; m_last = 1; m_held = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (r0 && r1) m_owner = (m_last == 1) ? 0 : 1;
            else if (r0) m_owner = 0;
            else if (r1) m_owner = 1;
            if (m_owner >= 0) begin m_last = m_owner; m_held = 1; end
        end else begin
            own_req = (m_owner == 0) ? r0 : r1;
            own_fin = (m_owner == 0) ? f0 : f1;
            oth_req = (m_owner == 0) ? r1 : r0;
            normal  = own_fin || !own_req;
            forced  = !normal && (m_held == MAX);
            m_to    = forced;
            if (normal || forced) begin
                if (oth_req) begin
                    m_owner = 1 - m_owner; m_last = m_owner; m_held = 1;
                end else m_owner = -1;
            end else m_held++;
        end
    endtask

    task automatic step(input logic rs, input logic r0, input logic r1, input logic f0, input logic f1);
        @(negedge clk);
        chk("grant_0", grant_0, m_owner == 0);
        chk("grant_1", grant_1, m_owner == 1);
        chk("selectorMUX", selectorMUX, m_owner == 1);
        chk("ocupado", ocupado, m_owner >= 0);
        chk("timeout_error", timeout_error, m_to);
        chk("grant_overlap", grant_0 && grant_1, 1'b0);
        reset = rs; req_0 = r0; req_1 = r1; fin_0 = f0; fin_1 = f1;
        model(rs, r0, r1, f0, f1);
        cyc++;
    endtask

    initial begin
        model(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1, 0, 0, 0, 0);
        // single requester with fin at cycle 3
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        // simultaneous requests after reset, handover on fin_0
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        // both held, fin pulses every other cycle
        for (int i = 0; i < 14; i++) step(0, 1, 1, i[0], i[0]);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        // req_1 held with no fin: timeout then re-grant
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 0);
        // fin_1 coinciding with the last allowed cycle
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, i == 16);
        // reset mid-grant with req_0 pending
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        // random traffic, fin rare so timeouts and handovers both occur
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        step(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
